// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - glyph constants and shared types for the seven-segment scan receiver
package seg_scan_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    typedef enum logic {
        FRAME_EMPTY = 1'b0,
        FRAME_FULL  = 1'b1
    } frame_state_e;

    // Active-low glyphs, bit 0 = segment a .. bit 6 = segment g
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_HEX_0 = 7'h40;
    localparam seg_t SEG_HEX_1 = 7'h79;
    localparam seg_t SEG_HEX_2 = 7'h24;
    localparam seg_t SEG_HEX_3 = 7'h30;
    localparam seg_t SEG_HEX_4 = 7'h19;
    localparam seg_t SEG_HEX_5 = 7'h12;
    localparam seg_t SEG_HEX_6 = 7'h02;
    localparam seg_t SEG_HEX_7 = 7'h78;
    localparam seg_t SEG_HEX_8 = 7'h00;
    localparam seg_t SEG_HEX_9 = 7'h10;
    localparam seg_t SEG_HEX_A = 7'h08;
    localparam seg_t SEG_HEX_B = 7'h03;
    localparam seg_t SEG_HEX_C = 7'h46;
    localparam seg_t SEG_HEX_D = 7'h21;
    localparam seg_t SEG_HEX_E = 7'h06;
    localparam seg_t SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational active-low glyph to hex nibble decoder
module seg_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] val_o,
    output logic       blank_o,
    output logic       err_o
);

    always_comb begin
        val_o   = 4'h0;
        blank_o = 1'b0;
        err_o   = 1'b0;
        case (seg_i)
            SEG_HEX_0: val_o = 4'h0;
            SEG_HEX_1: val_o = 4'h1;
            SEG_HEX_2: val_o = 4'h2;
            SEG_HEX_3: val_o = 4'h3;
            SEG_HEX_4: val_o = 4'h4;
            SEG_HEX_5: val_o = 4'h5;
            SEG_HEX_6: val_o = 4'h6;
            SEG_HEX_7: val_o = 4'h7;
            SEG_HEX_8: val_o = 4'h8;
            SEG_HEX_9: val_o = 4'h9;
            SEG_HEX_A: val_o = 4'hA;
            SEG_HEX_B: val_o = 4'hB;
            SEG_HEX_C: val_o = 4'hC;
            SEG_HEX_D: val_o = 4'hD;
            SEG_HEX_E: val_o = 4'hE;
            SEG_HEX_F: val_o = 4'hF;
            SEG_BLANK: blank_o = 1'b1;
            default:   err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - stability-qualified seven-segment scan receiver with frame handshake
// Optional frame watchdog driving stale is built only with SEG_SCAN_TIMEOUT_EN.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    overrun,
    output logic                    stale
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    seg_t                    seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q;
    logic [6+NUM_DIGITS:0]   prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dwell_q, dwell_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, out_val_q, out_val_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, out_blank_q, out_blank_d;
    logic [NUM_DIGITS-1:0]   sh_err_q, sh_err_d, out_err_q, out_err_d;
    frame_state_e            state_q, state_d;
    logic                    overrun_q, overrun_d;

    logic [NUM_DIGITS-1:0]   sel_oh;
    logic                    match, capture, complete;
    nibble_t                 dec_val;
    logic                    dec_blank, dec_err;

    seg_glyph_decode u_decode (
        .seg_i   (seg_s2_q),
        .val_o   (dec_val),
        .blank_o (dec_blank),
        .err_o   (dec_err)
    );

    assign sel_oh = ~sel_s2_q;
    assign match  = ({seg_s2_q, sel_s2_q} == prev_q);

    // Counter saturates, so done_dwell is what limits a long dwell to one capture
    always_comb begin
        cnt_d   = '0;
        dwell_d = 1'b0;
        if (match) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            dwell_d = dwell_q;
        end
        capture = (cnt_d == CNT_MAX) && $onehot(sel_oh) && !dwell_d;
        if (capture) begin
            dwell_d = 1'b1;
        end
    end

    // Completion looks at seen_d so a last-slot capture joins the frame it completes
    always_comb begin
        seen_d      = seen_q;
        sh_val_d    = sh_val_q;
        sh_blank_d  = sh_blank_q;
        sh_err_d    = sh_err_q;
        state_d     = state_q;
        out_val_d   = out_val_q;
        out_blank_d = out_blank_q;
        out_err_d   = out_err_q;
        overrun_d   = 1'b0;
        if (capture) begin
            seen_d = seen_q | sel_oh;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_oh[i]) begin
                    sh_val_d[4*i +: 4] = dec_val;
                    sh_blank_d[i]      = dec_blank;
                    sh_err_d[i]        = dec_err;
                end
            end
        end
        complete = &seen_d;
        if (state_q == FRAME_FULL && frame_ready) begin
            state_d = FRAME_EMPTY;
        end
        if (complete) begin
            seen_d = '0;
            if (state_q == FRAME_EMPTY || frame_ready) begin
                state_d     = FRAME_FULL;
                out_val_d   = sh_val_d;
                out_blank_d = sh_blank_d;
                out_err_d   = sh_err_d;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1_q    <= '0;
            seg_s2_q    <= '0;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            dwell_q     <= 1'b0;
            seen_q      <= '0;
            sh_val_q    <= '0;
            sh_blank_q  <= '0;
            sh_err_q    <= '0;
            state_q     <= FRAME_EMPTY;
            out_val_q   <= '0;
            out_blank_q <= '0;
            out_err_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            seg_s1_q    <= seg_n;
            seg_s2_q    <= seg_s1_q;
            sel_s1_q    <= dig_sel_n;
            sel_s2_q    <= sel_s1_q;
            prev_q      <= {seg_s2_q, sel_s2_q};
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            seen_q      <= seen_d;
            sh_val_q    <= sh_val_d;
            sh_blank_q  <= sh_blank_d;
            sh_err_q    <= sh_err_d;
            state_q     <= state_d;
            out_val_q   <= out_val_d;
            out_blank_q <= out_blank_d;
            out_err_q   <= out_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_valid = (state_q == FRAME_FULL);
    assign digit_val   = out_val_q;
    assign digit_blank = out_blank_q;
    assign digit_err   = out_err_q;
    assign overrun     = overrun_q;

`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q;
    logic            stale_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            stale_q <= 1'b0;
        end else if (complete) begin
            wd_q    <= '0;
            stale_q <= 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            stale_q <= 1'b1;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign stale = stale_q;
`else
    assign stale = 1'b0;
`endif

endmodule
